// File: rtl/jbi_sc2_req_tx_if.sv
// JBI->SCTAG2 request-path bundle: request queue handshake, write-buffer read port, SCTAG2 beats and credit return.
// master = transmitter side, slave = environment (request queue, write buffer, SCTAG2).
interface jbi_sc2_req_tx_if #(
    parameter int CRED_W = 3
);
    logic              req_vld;
    logic              req_rdy;
    logic [63:0]       req_hdr;
    logic              req_wr;
    logic              buf_rd_en;
    logic [3:0]        buf_rd_addr;
    logic [31:0]       buf_rd_data;
    logic [6:0]        buf_rd_ecc;
    logic [31:0]       jbi_sctag_req;
    logic [6:0]        jbi_scbuf_ecc;
    logic              jbi_sctag_req_vld;
    logic              sctag_jbi_iq_dequeue;
    logic              req_done;
    logic [CRED_W-1:0] credit_cnt;
    logic              cred_err;

    modport master (
        input  req_vld, req_hdr, req_wr, buf_rd_data, buf_rd_ecc, sctag_jbi_iq_dequeue,
        output req_rdy, buf_rd_en, buf_rd_addr, jbi_sctag_req, jbi_scbuf_ecc,
               jbi_sctag_req_vld, req_done, credit_cnt, cred_err
    );

    modport slave (
        output req_vld, req_hdr, req_wr, buf_rd_data, buf_rd_ecc, sctag_jbi_iq_dequeue,
        input  req_rdy, buf_rd_en, buf_rd_addr, jbi_sctag_req, jbi_scbuf_ecc,
               jbi_sctag_req_vld, req_done, credit_cnt, cred_err
    );
endinterface

// File: rtl/jbi_sc2_req_tx.sv
// JBI->SCTAG2 request serialiser: header beats at T+1/T+2, write data T+3..T+18; req_rdy low unless IDLE with credit.
// JBI_SC2_REQ_TX_CRED_CHK_EN adds the sticky cred_err overflow check; otherwise cred_err is tied low.
module jbi_sc2_req_tx #(
    parameter int IQ_DEPTH = 4,
    parameter int CRED_W   = 3
) (
    input  logic               rclk,
    input  logic               rst,
    jbi_sc2_req_tx_if.master   bus
);
    typedef enum logic [1:0] {IDLE, HDR0, HDR1, DATA} state_t;

    localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(IQ_DEPTH);

    state_t            state_q;
    logic [31:0]       hdr_lo_q;
    logic              wr_q;
    logic [4:0]        cnt_q;
    logic              rd_en_q;
    logic [31:0]       req_q;
    logic [6:0]        ecc_q;
    logic              vld_q;
    logic              done_q;
    logic [CRED_W-1:0] cred_q;
    logic [CRED_W-1:0] cred_d;
    logic              accept;
    logic              deq;
    logic              rd_en;

    assign deq     = bus.sctag_jbi_iq_dequeue;
    assign accept  = bus.req_vld && bus.req_rdy;
    assign bus.req_rdy = (state_q == IDLE) && (cred_q != '0);

    // cnt_q is 0 in HDR0, so reads issue on the 16 cycles starting there
    assign rd_en           = wr_q && (state_q != IDLE) && !cnt_q[4];
    assign bus.buf_rd_en   = rd_en;
    assign bus.buf_rd_addr = rd_en ? cnt_q[3:0] : 4'd0;

    assign bus.jbi_sctag_req     = req_q;
    assign bus.jbi_scbuf_ecc     = ecc_q;
    assign bus.jbi_sctag_req_vld = vld_q;
    assign bus.req_done          = done_q;
    assign bus.credit_cnt        = cred_q;

    always_comb begin
        cred_d = cred_q;
        if (accept && !deq)
            cred_d = cred_q - CRED_W'(1);
        else if (deq && !accept && cred_q != CRED_MAX)
            cred_d = cred_q + CRED_W'(1);
    end

    always_ff @(posedge rclk or posedge rst) begin
        if (rst)
            cred_q <= CRED_MAX;
        else
            cred_q <= cred_d;
    end

    always_ff @(posedge rclk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            hdr_lo_q <= '0;
            wr_q     <= 1'b0;
            cnt_q    <= '0;
            rd_en_q  <= 1'b0;
            req_q    <= '0;
            ecc_q    <= '0;
            vld_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            req_q   <= '0;
            ecc_q   <= '0;
            vld_q   <= 1'b0;
            done_q  <= 1'b0;
            rd_en_q <= rd_en;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        hdr_lo_q <= bus.req_hdr[31:0];
                        wr_q     <= bus.req_wr;
                        cnt_q    <= '0;
                        req_q    <= bus.req_hdr[63:32];
                        vld_q    <= 1'b1;
                        state_q  <= HDR0;
                    end
                end
                HDR0: begin
                    cnt_q   <= cnt_q + 5'd1;
                    req_q   <= hdr_lo_q;
                    done_q  <= !wr_q;
                    state_q <= HDR1;
                end
                HDR1: begin
                    cnt_q   <= cnt_q + 5'd1;
                    state_q <= wr_q ? DATA : IDLE;
                end
                DATA: begin
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == 5'd16)
                        done_q <= 1'b1;
                    if (cnt_q == 5'd17)
                        state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
            // read data returns one cycle after the strobe and is re-driven the following cycle
            if (rd_en_q) begin
                req_q <= bus.buf_rd_data;
                ecc_q <= bus.buf_rd_ecc;
            end
        end
    end

`ifdef JBI_SC2_REQ_TX_CRED_CHK_EN
    logic err_q;

    always_ff @(posedge rclk or posedge rst) begin
        if (rst)
            err_q <= 1'b0;
        else if (deq && !accept && cred_q == CRED_MAX)
            err_q <= 1'b1;
    end

    assign bus.cred_err = err_q;
`else
    assign bus.cred_err = 1'b0;
`endif
endmodule

// File: tb/tb_jbi_sc2_req_tx.sv
// Bench for jbi_sc2_req_tx: vector table of transactions plus hand sequences for credit exhaustion,
// saturation and mid-write reset; expected beats and read strobes are queued at accept time.
module tb_jbi_sc2_req_tx;
    localparam int IQ_DEPTH = 4;
    localparam int CRED_W   = 3;
`ifdef JBI_SC2_REQ_TX_CRED_CHK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic rclk = 1'b0;
    logic rst;
    always #5 rclk = ~rclk;

    jbi_sc2_req_tx_if #(.CRED_W(CRED_W)) bus();

    jbi_sc2_req_tx #(.IQ_DEPTH(IQ_DEPTH), .CRED_W(CRED_W)) dut (
        .rclk (rclk),
        .rst  (rst),
        .bus  (bus.master)
    );

    typedef struct {
        logic [63:0] hdr;
        logic        wr;
        logic [31:0] dbase;
        logic [6:0]  ebase;
        logic        deq;
        int          exp_cred;
    } vec_t;

    typedef struct {
        int          cyc;
        logic [31:0] req;
        logic [6:0]  ecc;
        logic        vld;
        logic        done;
    } beat_t;

    typedef struct {
        int         cyc;
        logic [3:0] addr;
    } rd_t;

    beat_t       beat_q[$];
    rd_t         rd_q[$];
    int          cyc;
    int          free_cyc;
    int          exp_cred;
    logic        exp_err;
    int          n_cmp;
    int          n_bad;
    logic        last_acc;
    int          acc_cyc;
    logic [31:0] cur_dbase;
    logic [6:0]  cur_ebase;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    task automatic check_outputs();
        beat_t b;
        rd_t   r;
        if (beat_q.size() != 0 && beat_q[0].cyc == cyc) begin
            b = beat_q.pop_front();
            chk("beat_req", bus.jbi_sctag_req, b.req);
            chk("beat_ecc", bus.jbi_scbuf_ecc, b.ecc);
            chk("beat_vld", bus.jbi_sctag_req_vld, b.vld);
            chk("beat_done", bus.req_done, b.done);
        end else begin
            chk("idle_bus", {bus.jbi_sctag_req, bus.jbi_scbuf_ecc, bus.jbi_sctag_req_vld, bus.req_done}, 0);
        end
        if (rd_q.size() != 0 && rd_q[0].cyc == cyc) begin
            r = rd_q.pop_front();
            chk("rd_en", bus.buf_rd_en, 1);
            chk("rd_addr", bus.buf_rd_addr, r.addr);
        end else begin
            chk("rd_idle", bus.buf_rd_en, 0);
        end
        chk("credit_cnt", bus.credit_cnt, exp_cred);
        chk("cred_err", bus.cred_err, exp_err);
    endtask

    // one clock: model accept/credit at end of cycle, then buffer response and output checks after the edge
    task automatic tick();
        logic       acc;
        logic       deq;
        logic       en;
        logic [3:0] a;
        beat_t      b;
        rd_t        r;
        #1;
        acc = bus.req_vld && bus.req_rdy;
        deq = bus.sctag_jbi_iq_dequeue;
        en  = bus.buf_rd_en;
        a   = bus.buf_rd_addr;
        chk("req_rdy", bus.req_rdy, (cyc >= free_cyc) && (exp_cred != 0));
        last_acc = acc;
        if (acc) begin
            acc_cyc = cyc;
            b = '{cyc + 1, bus.req_hdr[63:32], 7'h0, 1'b1, 1'b0};
            beat_q.push_back(b);
            b = '{cyc + 2, bus.req_hdr[31:0], 7'h0, 1'b0, !bus.req_wr};
            beat_q.push_back(b);
            if (bus.req_wr) begin
                for (int k = 0; k < 16; k++) begin
                    b = '{cyc + 3 + k, cur_dbase + 32'(k), cur_ebase | 7'(k), 1'b0, (k == 15)};
                    beat_q.push_back(b);
                    r = '{cyc + 1 + k, 4'(k)};
                    rd_q.push_back(r);
                end
            end
            free_cyc = cyc + (bus.req_wr ? 19 : 3);
        end
        if (CHK_EN && deq && !acc && exp_cred == IQ_DEPTH)
            exp_err = 1'b1;
        if (acc && !deq)
            exp_cred--;
        else if (deq && !acc && exp_cred < IQ_DEPTH)
            exp_cred++;
        @(posedge rclk);
        cyc++;
        #1;
        if (en) begin
            bus.buf_rd_data = cur_dbase + {28'h0, a};
            bus.buf_rd_ecc  = cur_ebase | {3'b0, a};
        end else begin
            bus.buf_rd_data = $urandom;
            bus.buf_rd_ecc  = 7'($urandom);
        end
        check_outputs();
    endtask

    task automatic wait_rdy();
        for (int i = 0; i < 40 && !bus.req_rdy; i++)
            tick();
        chk("wait_rdy", bus.req_rdy, 1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 60 && (beat_q.size() != 0 || cyc < free_cyc); i++)
            tick();
        chk("drain", beat_q.size(), 0);
    endtask

    task automatic offer(input vec_t v);
        wait_rdy();
        cur_dbase = v.dbase;
        cur_ebase = v.ebase;
        bus.req_hdr = v.hdr;
        bus.req_wr  = v.wr;
        bus.req_vld = 1'b1;
        bus.sctag_jbi_iq_dequeue = v.deq;
        tick();
        bus.req_vld = 1'b0;
        bus.sctag_jbi_iq_dequeue = 1'b0;
        chk("accepted", last_acc, 1);
        chk("cred_after_accept", bus.credit_cnt, v.exp_cred);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1);
    end

    initial begin
        vec_t vecs[5];
        vec_t v;
        vecs[0] = '{64'hA5A5_0001_DEAD_BEEF, 1'b0, 32'h0,         7'h00, 1'b0, 3};
        vecs[1] = '{64'h1111_2222_3333_4444, 1'b1, 32'h1000_0000, 7'h00, 1'b0, 2};
        vecs[2] = '{64'hCAFE_0002_0BAD_0003, 1'b0, 32'h0,         7'h00, 1'b1, 2};
        vecs[3] = '{64'h0000_0000_FFFF_FFFF, 1'b0, 32'h0,         7'h00, 1'b0, 1};
        vecs[4] = '{64'h8000_0001_7FFF_FFFE, 1'b1, 32'h3C00_0000, 7'h20, 1'b0, 0};

        n_cmp = 0; n_bad = 0; cyc = 0; free_cyc = 0;
        exp_cred = IQ_DEPTH; exp_err = 1'b0; last_acc = 1'b0; acc_cyc = 0;
        cur_dbase = '0; cur_ebase = '0;
        rst = 1'b1;
        bus.req_vld = 1'b0; bus.req_hdr = '0; bus.req_wr = 1'b0;
        bus.buf_rd_data = '0; bus.buf_rd_ecc = '0; bus.sctag_jbi_iq_dequeue = 1'b0;
        #1;
        chk("reset_bus", {bus.jbi_sctag_req, bus.jbi_scbuf_ecc, bus.jbi_sctag_req_vld, bus.req_done}, 0);
        chk("reset_rd", {bus.buf_rd_en, bus.buf_rd_addr}, 0);
        chk("reset_cred", bus.credit_cnt, IQ_DEPTH);
        chk("reset_err", bus.cred_err, 0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        for (int i = 0; i < 5; i++)
            offer(vecs[i]);
        wait_idle();

        // credits exhausted: offer held until one credit returns
        bus.req_hdr = 64'h0BAD_F00D_1234_5678;
        bus.req_wr  = 1'b0;
        bus.req_vld = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rdy_no_credit", bus.req_rdy, 0);
        end
        bus.sctag_jbi_iq_dequeue = 1'b1;
        tick();
        bus.sctag_jbi_iq_dequeue = 1'b0;
        chk("rdy_after_deq", bus.req_rdy, 1);
        tick();
        bus.req_vld = 1'b0;
        chk("fifth_accepted", last_acc, 1);
        chk("cred_after_fifth", bus.credit_cnt, 0);
        wait_idle();

        // refill, then one dequeue too many
        bus.sctag_jbi_iq_dequeue = 1'b1;
        repeat (4) tick();
        chk("cred_refill", bus.credit_cnt, IQ_DEPTH);
        tick();
        bus.sctag_jbi_iq_dequeue = 1'b0;
        chk("cred_sat", bus.credit_cnt, IQ_DEPTH);
        chk("cred_err_sat", bus.cred_err, CHK_EN);
        repeat (3) tick();
        chk("cred_err_hold", bus.cred_err, CHK_EN);

        // reset while word 7 is on the bus
        v = '{64'h5555_6666_7777_8888, 1'b1, 32'h5500_0000, 7'h10, 1'b0, 3};
        offer(v);
        for (int i = 0; i < 20 && cyc < acc_cyc + 10; i++)
            tick();
        rst = 1'b1;
        #1;
        chk("rst_mid_bus", {bus.jbi_sctag_req, bus.jbi_scbuf_ecc, bus.jbi_sctag_req_vld, bus.req_done}, 0);
        chk("rst_mid_rd", bus.buf_rd_en, 0);
        chk("rst_mid_cred", bus.credit_cnt, IQ_DEPTH);
        chk("rst_mid_err", bus.cred_err, 0);
        beat_q.delete();
        rd_q.delete();
        exp_cred = IQ_DEPTH;
        exp_err  = 1'b0;
        free_cyc = 0;
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++)
            tick();

        v = '{64'h2468_ACE0_1357_9BDF, 1'b1, 32'h2000_0000, 7'h40, 1'b0, 3};
        offer(v);
        wait_idle();
        v = '{64'hFEED_0004_BEEF_0005, 1'b0, 32'h0, 7'h00, 1'b1, 3};
        offer(v);
        wait_idle();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/jbi_sc2_req_tx.md
Name: jbi_sc2_req_tx

Overview:
- JBI-side transmitter for the JBI-to-SCTAG2 request path; sourcing end of the jbi_sctag_req / jbi_scbuf_ecc / jbi_sctag_req_vld interface, consumer of sctag_jbi_iq_dequeue credit returns.
- Accepts one transaction at a time from the JBI request queue: a 64-bit header, plus a 64B payload for writes.
- Serialises the transaction into 32-bit beats, fetching payload words and ECC from the JBI write buffer through a 1-cycle-latency read port.
- Enforces IQ flow control with a credit counter.

Parameters:
IQ_DEPTH, 4, SCTAG2 input-queue entries, which is the initial and maximum credit count
CRED_W, 3, credit counter width; must satisfy 2^CRED_W > IQ_DEPTH

Ports:
rclk  in  1  clock
rst  in  1  asynchronous active-high reset
req_vld  in  1  transaction offered
req_rdy  out  1  transaction accepted when req_vld && req_rdy
req_hdr  in  64  request header
req_wr  in  1  transaction carries 16-word payload
buf_rd_en  out  1  write-buffer read strobe
buf_rd_addr  out  4  payload word index
buf_rd_data  in  32  payload word, valid cycle after buf_rd_en
buf_rd_ecc  in  7  ECC of buf_rd_data, same timing
jbi_sctag_req  out  32  request beat to SCTAG2
jbi_scbuf_ecc  out  7  ECC of data beat
jbi_sctag_req_vld  out  1  first-beat marker
sctag_jbi_iq_dequeue  in  1  one-cycle pulse returning one credit
req_done  out  1  pulse in the cycle the last beat is driven
credit_cnt  out  CRED_W  available credits
cred_err  out  1  sticky credit overflow (optional feature only)

Behaviour:
- Reset (async, immediate): state IDLE. jbi_sctag_req=0, jbi_scbuf_ecc=0, jbi_sctag_req_vld=0, req_done=0, buf_rd_en=0, buf_rd_addr=0, credit_cnt=IQ_DEPTH, cred_err=0. Any in-flight transaction is dropped with no further beats.
- All bus outputs (jbi_sctag_req, jbi_scbuf_ecc, jbi_sctag_req_vld, req_done) are registered. Outside valid beats they are 0.
- req_rdy = (state==IDLE) && (credit_cnt!=0), combinational.
- States IDLE, HDR0, HDR1, DATA. For an accept in cycle T:
  - T: header and req_wr are captured; credit is decremented.
  - T+1, HDR0: jbi_sctag_req=hdr[63:32], jbi_sctag_req_vld=1.
  - T+2, HDR1: jbi_sctag_req=hdr[31:0], vld=0.
  - Read (req_wr=0): req_done=1 at T+2, then IDLE.
  - Write (req_wr=1): buf_rd_en=1 T+1..T+16, with buf_rd_addr=0..15 (combinational from state and word counter). Words 0..15 are registered from buf_rd_data/buf_rd_ecc and driven T+3..T+18 in DATA. jbi_scbuf_ecc is nonzero only on data beats. req_done=1 at T+18, then IDLE.
- Earliest next accept is the cycle after req_done, so back-to-back transactions have exactly one idle bus cycle between them.
- Credits:
  - accept only: -1
  - dequeue only: +1
  - both in the same cycle: unchanged
  - dequeue at IQ_DEPTH: saturates at IQ_DEPTH
  - credit_cnt=0: req_rdy=0; a transaction is never split for lack of credit.
- req_vld with req_rdy low: nothing is captured; the offer is held upstream.

Optional Feature:
JBI_SC2_REQ_TX_CRED_CHK_EN
- Defined: cred_err is set when sctag_jbi_iq_dequeue arrives with credit_cnt==IQ_DEPTH and no simultaneous accept. It is sticky until rst.
- Undefined: the port is still present, tied to 0, and there is no check logic. Saturation behaviour is identical in both builds.

Test Plan:
- Reset, then read req_hdr=64'hA5A5_0001_DEAD_BEEF, req_wr=0 -> A5A50001 with vld=1 at T+1, DEADBEEF with vld=0 and req_done=1 at T+2; credit_cnt goes 4->3; no buf_rd_en.
- Write with buffer words 32'h1000_0000+k and ecc=k -> buf_rd_en T+1..T+16 with addr 0..15; words appear T+3..T+18 with jbi_scbuf_ecc=k; req_done only at T+18.
- Issue 4 reads with no dequeue -> 5th req_vld sees req_rdy=0. One dequeue pulse -> req_rdy=1 the following cycle and the 5th read proceeds.
- Dequeue pulse in the same cycle as an accept at credit_cnt=2 -> credit_cnt stays 2.
- rst asserted mid-DATA at word 7 -> outputs go to 0 immediately, credit_cnt=4, no further beats; a new write after reset restarts from addr 0.
- With JBI_SC2_REQ_TX_CRED_CHK_EN defined, dequeue at credit_cnt=4 -> cred_err=1 and held; credit_cnt stays 4. Without the macro, cred_err stays 0.
